// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-setting controller.
package time_set_pkg;

    typedef enum logic [2:0] {
        RUN,
        EDIT_HR,
        EDIT_MIN,
        EDIT_SEC,
        COMMIT
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HR   = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam int HR_MAX = 23;
    localparam int MS_MAX = 59;

    function automatic logic [1:0] field_of(input state_t s);
        case (s)
            EDIT_HR:  return FIELD_HR;
            EDIT_MIN: return FIELD_MIN;
            EDIT_SEC: return FIELD_SEC;
            default:  return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bcd2_adj.sv
// Two-digit BCD step up/down with wrap at MAX and clamp of illegal values to 00.
module bcd2_adj #(
    parameter int MAX = 59
) (
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] adj_tens,
    output logic [3:0] adj_ones,
    output logic       legal
);
    localparam logic [3:0] MAX_T = 4'(MAX / 10);
    localparam logic [3:0] MAX_O = 4'(MAX % 10);

    logic at_max;
    logic at_zero;

    always_comb begin
        legal    = (ones <= 4'd9) && ((tens < MAX_T) || ((tens == MAX_T) && (ones <= MAX_O)));
        at_max   = (tens == MAX_T) && (ones == MAX_O);
        at_zero  = (tens == 4'd0) && (ones == 4'd0);
        adj_tens = tens;
        adj_ones = ones;
        if ((inc || dec) && !legal) begin
            adj_tens = 4'd0;
            adj_ones = 4'd0;
        end else if (inc) begin
            if (at_max) begin
                adj_tens = 4'd0;
                adj_ones = 4'd0;
            end else if (ones == 4'd9) begin
                adj_tens = tens + 4'd1;
                adj_ones = 4'd0;
            end else begin
                adj_ones = ones + 4'd1;
            end
        end else if (dec) begin
            if (at_zero) begin
                adj_tens = MAX_T;
                adj_ones = MAX_O;
            end else if (ones == 4'd0) begin
                adj_tens = tens - 4'd1;
                adj_ones = 4'd9;
            end else begin
                adj_ones = ones - 4'd1;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven editor for the BCD clock: captures live time, steps fields,
// and commits through a one-cycle load strobe while holding the counter stopped.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 600,
    parameter int BLINK_DIV      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [3:0] cur_sec_ones,
    input  logic [3:0] cur_sec_tens,
    input  logic [3:0] cur_min_ones,
    input  logic [3:0] cur_min_tens,
    input  logic [3:0] cur_hr_ones,
    input  logic [3:0] cur_hr_tens,
    output logic [3:0] load_sec_ones,
    output logic [3:0] load_sec_tens,
    output logic [3:0] load_min_ones,
    output logic [3:0] load_min_tens,
    output logic [3:0] load_hr_ones,
    output logic [3:0] load_hr_tens,
    output logic       load,
    output logic       enable,
    output logic [1:0] edit_field,
    output logic       blink
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    state_t          state_reg, state_next;
    logic [2:0]      prev_reg, edge_reg;
    logic [TW-1:0]   tcnt_reg, tcnt_next;
    logic [BW-1:0]   bcnt_reg;
    // Digit order, index 5..0: hr tens, hr ones, min tens, min ones, sec tens, sec ones.
    logic [5:0][3:0] buf_reg, buf_next, adj_buf, clean_buf;
    logic [2:0]      legal, field_sel;
    logic            mode_e, inc_e, dec_e, any_e, step_inc, step_dec;

    assign mode_e   = edge_reg[2];
    assign inc_e    = edge_reg[1];
    assign dec_e    = edge_reg[0];
    assign any_e    = |edge_reg;
    assign step_inc = inc_e & ~dec_e & ~mode_e;
    assign step_dec = dec_e & ~inc_e & ~mode_e;
    assign field_sel = {state_reg == EDIT_HR, state_reg == EDIT_MIN, state_reg == EDIT_SEC};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_field
            localparam int FMAX = (gi == 2) ? HR_MAX : MS_MAX;
            bcd2_adj #(.MAX(FMAX)) u_adj (
                .tens     (buf_reg[2*gi+1]),
                .ones     (buf_reg[2*gi]),
                .inc      (step_inc & field_sel[gi]),
                .dec      (step_dec & field_sel[gi]),
                .adj_tens (adj_buf[2*gi+1]),
                .adj_ones (adj_buf[2*gi]),
                .legal    (legal[gi])
            );
            // Unadjusted illegal captures must never reach the counter.
            assign clean_buf[2*gi+1] = legal[gi] ? buf_reg[2*gi+1] : 4'd0;
            assign clean_buf[2*gi]   = legal[gi] ? buf_reg[2*gi]   : 4'd0;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        buf_next   = buf_reg;
        tcnt_next  = '0;
        case (state_reg)
            RUN: begin
                if (mode_e) begin
                    state_next = EDIT_HR;
                    buf_next   = {cur_hr_tens, cur_hr_ones, cur_min_tens,
                                  cur_min_ones, cur_sec_tens, cur_sec_ones};
                end
            end
            EDIT_HR, EDIT_MIN, EDIT_SEC: begin
                tcnt_next = any_e ? '0 : tcnt_reg + TW'(1);
                if (mode_e) begin
                    if (state_reg == EDIT_HR) begin
                        state_next = EDIT_MIN;
                    end else if (state_reg == EDIT_MIN) begin
                        state_next = EDIT_SEC;
                    end else begin
                        state_next = COMMIT;
                        buf_next   = clean_buf;
                    end
                end else if (!any_e && (tcnt_reg == TW'(TIMEOUT_CYCLES - 1))) begin
                    state_next = RUN;
                end else if (step_inc || step_dec) begin
                    buf_next = adj_buf;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= RUN;
            prev_reg   <= '0;
            edge_reg   <= '0;
            tcnt_reg   <= '0;
            bcnt_reg   <= '0;
            buf_reg    <= '0;
            load       <= 1'b0;
            enable     <= 1'b1;
            edit_field <= FIELD_NONE;
            blink      <= 1'b0;
        end else begin
            prev_reg   <= {btn_mode, btn_inc, btn_dec};
            edge_reg   <= {btn_mode, btn_inc, btn_dec} & ~prev_reg;
            state_reg  <= state_next;
            tcnt_reg   <= tcnt_next;
            buf_reg    <= buf_next;
            load       <= (state_next == COMMIT);
            enable     <= (state_next == RUN);
            edit_field <= field_of(state_next);
            if ((field_of(state_next) == FIELD_NONE) || (state_next != state_reg)) begin
                bcnt_reg <= '0;
                blink    <= 1'b0;
            end else if (bcnt_reg == BW'(BLINK_DIV - 1)) begin
                bcnt_reg <= '0;
                blink    <= ~blink;
            end else begin
                bcnt_reg <= bcnt_reg + BW'(1);
            end
        end
    end

    assign load_hr_tens  = buf_reg[5];
    assign load_hr_ones  = buf_reg[4];
    assign load_min_tens = buf_reg[3];
    assign load_min_ones = buf_reg[2];
    assign load_sec_tens = buf_reg[1];
    assign load_sec_ones = buf_reg[0];

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: capture, commit, wrap, clamp, timeout, reset.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [3:0] cur_sec_ones = 0, cur_sec_tens = 0, cur_min_ones = 0;
    logic [3:0] cur_min_tens = 0, cur_hr_ones = 0, cur_hr_tens = 0;
    logic [3:0] load_sec_ones, load_sec_tens, load_min_ones;
    logic [3:0] load_min_tens, load_hr_ones, load_hr_tens;
    logic       load, enable, blink;
    logic [1:0] edit_field;

    int checks = 0;
    int errors = 0;
    int load_count = 0;
    int loads_before;

    time_set_ctrl #(.TIMEOUT_CYCLES(8), .BLINK_DIV(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_mode      (btn_mode),
        .btn_inc       (btn_inc),
        .btn_dec       (btn_dec),
        .cur_sec_ones  (cur_sec_ones),
        .cur_sec_tens  (cur_sec_tens),
        .cur_min_ones  (cur_min_ones),
        .cur_min_tens  (cur_min_tens),
        .cur_hr_ones   (cur_hr_ones),
        .cur_hr_tens   (cur_hr_tens),
        .load_sec_ones (load_sec_ones),
        .load_sec_tens (load_sec_tens),
        .load_min_ones (load_min_ones),
        .load_min_tens (load_min_tens),
        .load_hr_ones  (load_hr_ones),
        .load_hr_tens  (load_hr_tens),
        .load          (load),
        .enable        (enable),
        .edit_field    (edit_field),
        .blink         (blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (load) load_count++;

    function automatic logic [23:0] buf_val();
        return {load_hr_tens, load_hr_ones, load_min_tens,
                load_min_ones, load_sec_tens, load_sec_ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_cur(input logic [23:0] t);
        {cur_hr_tens, cur_hr_ones, cur_min_tens, cur_min_ones, cur_sec_tens, cur_sec_ones} = t;
    endtask

    // Raise the chosen buttons for one cycle; returns once the action is visible.
    task automatic pulse(input logic m, input logic i, input logic d);
        btn_mode = m; btn_inc = i; btn_dec = d;
        @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        // Reset with buttons low so the cleared prev registers create no edge.
        reset = 1'b0;
        idle(2);
        check("rst_enable", 32'(enable), 32'd1);
        reset = 1'b1;
        idle(1);
        check("rst_load", 32'(load), 32'd0);
        check("rst_field", 32'(edit_field), 32'd0);
        check("rst_buf", 32'(buf_val()), 32'h000000);
        check("rst_blink", 32'(blink), 32'd0);
        idle(2);
        check("rst_noedge", 32'(edit_field), 32'd0);

        // Capture and commit 13:45:27.
        set_cur(24'h134527);
        pulse(1, 0, 0);
        check("cap_field", 32'(edit_field), 32'd1);
        check("cap_enable", 32'(enable), 32'd0);
        check("cap_buf", 32'(buf_val()), 32'h134527);
        check("blink_enter", 32'(blink), 32'd0);
        idle(1);
        check("blink_toggle", 32'(blink), 32'd1);
        pulse(1, 0, 0);
        check("min_field", 32'(edit_field), 32'd2);
        pulse(1, 0, 0);
        check("sec_field", 32'(edit_field), 32'd3);
        loads_before = load_count;
        pulse(1, 0, 0);
        check("commit_load", 32'(load), 32'd1);
        check("commit_en", 32'(enable), 32'd0);
        check("commit_buf", 32'(buf_val()), 32'h134527);
        idle(1);
        check("post_load", 32'(load), 32'd0);
        check("post_enable", 32'(enable), 32'd1);
        check("load_once", 32'(load_count - loads_before), 32'd1);

        // Wrap behaviour and simultaneous edges.
        set_cur(24'h235900);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        check("hr_inc_wrap", 32'(buf_val()), 32'h005900);
        pulse(0, 0, 1);
        check("hr_dec_wrap", 32'(buf_val()), 32'h235900);
        pulse(1, 1, 0);
        check("modeinc_fld", 32'(edit_field), 32'd2);
        check("modeinc_buf", 32'(buf_val()), 32'h235900);
        pulse(0, 1, 0);
        check("min_inc_wrap", 32'(buf_val()), 32'h230000);
        pulse(0, 1, 1);
        check("incdec_buf", 32'(buf_val()), 32'h230000);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        check("sec_dec_wrap", 32'(buf_val()), 32'h230059);
        pulse(1, 0, 0);
        check("commit2_load", 32'(load), 32'd1);
        check("commit2_buf", 32'(buf_val()), 32'h230059);
        idle(1);

        // Illegal hour clamp, 09 -> 10 carry, then timeout.
        set_cur(24'h250900);
        pulse(1, 0, 0);
        check("ill_cap", 32'(buf_val()), 32'h250900);
        pulse(0, 1, 0);
        check("ill_clamp", 32'(buf_val()), 32'h000900);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        check("min_carry", 32'(buf_val()), 32'h001000);
        loads_before = load_count;
        idle(7);
        check("to_still", 32'(edit_field), 32'd2);
        idle(1);
        check("to_field", 32'(edit_field), 32'd0);
        check("to_enable", 32'(enable), 32'd1);
        check("to_noload", 32'(load_count - loads_before), 32'd0);

        // Reset in the middle of an edit.
        set_cur(24'h073000);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        check("mid_field", 32'(edit_field), 32'd2);
        check("mid_buf", 32'(buf_val()), 32'h073000);
        loads_before = load_count;
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        check("mr_field", 32'(edit_field), 32'd0);
        check("mr_enable", 32'(enable), 32'd1);
        check("mr_buf", 32'(buf_val()), 32'h000000);
        idle(2);
        check("mr_noload", 32'(load_count - loads_before), 32'd0);
        check("mr_run", 32'(edit_field), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
